coeff_stream_packer: RTL and testbench
======================================

COEFF_STREAM_PACKER -- requirements
Module: coeff_stream_packer

Interface
REQ-001 SHALL have ports: clk  input  1  single clock, all logic on rising edge.
REQ-002 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-003 SHALL have port: in_tdata  input  13  result coefficient from the multiplier output stream.
REQ-004 SHALL have port: in_tvalid  input  1  coefficient valid.
REQ-005 SHALL have port: in_tready  output  1  packer accepts a coefficient.
REQ-006 SHALL have port: in_tlast  input  1  final coefficient of the polynomial (multiplier done).
REQ-007 SHALL have port: poly_q  input  2  modulus select: 0->11-bit, 1->12-bit, 2->13-bit, 3->13-bit coefficients.
REQ-008 SHALL have port: M_AXIS_tdata  output  32  bit-packed output word.
REQ-009 SHALL have ports M_AXIS_tvalid output 1, M_AXIS_tready input 1, M_AXIS_tlast output 1 (AXI-Stream to DMA S2MM).
REQ-010 SHALL have port: busy  output  1  high from the first accepted coefficient until the tlast word handshakes.

Function
REQ-011 SHALL hold a 44-bit accumulator acc and a 6-bit fill count cnt (valid bits in acc, LSB-aligned).
REQ-012 SHALL latch coefficient width w from poly_q on the first accepted beat of each packet; poly_q changes mid-packet SHALL be ignored.
REQ-013 SHALL mask each accepted coefficient to w bits, OR it into acc at bit position cnt, and add w to cnt.
REQ-014 SHALL drive in_tready = (cnt < 32) and no flush pending and not reset.
REQ-015 SHALL set flush pending when a beat with in_tlast=1 is accepted.
REQ-016 SHALL drive M_AXIS_tvalid = (cnt >= 32) or (flush pending and cnt > 0).
REQ-017 SHALL drive M_AXIS_tdata = acc[31:0], zero-padding bits at and above cnt when cnt < 32.
REQ-018 SHALL drive M_AXIS_tlast = flush pending and cnt <= 32.
REQ-019 On output handshake, SHALL shift acc right by 32 (zero fill) and subtract min(32, cnt) from cnt.
REQ-020 On the tlast handshake, SHALL clear flush pending, acc, cnt, and busy; the next beat starts a new packet at bit 0.
REQ-021 Input acceptance and output handshake SHALL be mutually exclusive per cycle (guaranteed by REQ-014/016).
REQ-022 Output word SHALL be registered; latency from the accepted beat that completes a word to M_AXIS_tvalid high SHALL be 1 cycle.
REQ-023 While M_AXIS_tvalid=1 and M_AXIS_tready=0, M_AXIS_tdata and M_AXIS_tlast SHALL stay stable.
REQ-024 Packet whose total bit count is a multiple of 32 SHALL end with exactly that many words; no trailing empty word.
REQ-025 Total output words per packet SHALL equal ceil(N*w/32) for N coefficients.
REQ-026 A packet SHALL contain at least one coefficient; a tlast-only empty packet is not supported.

Reset
REQ-027 With reset=1 at a rising edge, acc=0, cnt=0, flush pending=0, latched w=13.
REQ-028 During and after reset, in_tready, M_AXIS_tvalid, M_AXIS_tlast, and busy SHALL be 0, and M_AXIS_tdata SHALL be 0.
REQ-029 Reset mid-packet SHALL discard all partial data; the next packet SHALL pack from bit 0.

Verification
REQ-030 Test poly_q=0, input 0x7FF, 0x001, 0x400 (last) -> word 0x00000FFF with tlast=0, then 0x00000001 with tlast=1.
REQ-031 Test poly_q=1, eight coefficients of 0xABC, last on the 8th -> exactly 3 words: 0xBCABCABC, 0xCABCABCA, 0xABCABCAB (tlast).
REQ-032 Test poly_q=2, 509 coefficients of 0x1FFF -> 207 words: 206 of 0xFFFFFFFF, then 0x01FFFFFF with tlast=1.
REQ-033 Test poly_q=0 with input 0x1FFF -> only 0x7FF packed (upper bits masked off); toggle poly_q mid-packet -> width unchanged.
REQ-034 Test M_AXIS_tready=0 for 10 cycles while a word is pending -> tvalid held high, tdata stable, and in_tready=0 while cnt >= 32.
REQ-035 Test reset asserted after 5 coefficients of a packet -> all outputs 0; a following packet matches the REQ-030 expected words exactly.

Source files
------------

// File: rtl/coeff_stream_packer.sv
// Bit-packs 11/12/13-bit coefficients from the multiplier stream into 32-bit
// AXI-Stream words for the DMA, with a short final word flushed on in_tlast.
module coeff_stream_packer #(
    parameter int DATA_W = 13
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] in_tdata,
    input  logic              in_tvalid,
    output logic              in_tready,
    input  logic              in_tlast,
    input  logic [1:0]        poly_q,
    output logic [31:0]       M_AXIS_tdata,
    output logic              M_AXIS_tvalid,
    input  logic              M_AXIS_tready,
    output logic              M_AXIS_tlast,
    output logic              busy
);

    localparam int ACC_W = 44;

    logic [ACC_W-1:0] acc, acc_nxt;
    logic [5:0]       cnt, cnt_nxt;
    logic             flush, flush_nxt;
    logic [3:0]       w, w_nxt, w_beat;
    logic             busy_nxt;
    logic             in_fire, out_fire;

    function automatic logic [3:0] width_of(input logic [1:0] q);
        case (q)
            2'd0:    return 4'd11;
            2'd1:    return 4'd12;
            default: return 4'd13;
        endcase
    endfunction

    function automatic logic [ACC_W-1:0] place(input logic [DATA_W-1:0] d,
                                               input logic [3:0]        wd,
                                               input logic [5:0]        pos);
        logic [ACC_W-1:0] mask;
        mask = (ACC_W'(1) << wd) - ACC_W'(1);
        return (ACC_W'(d) & mask) << pos;
    endfunction

    assign in_tready = (cnt < 6'd32) && !flush && !reset;
    assign in_fire   = in_tvalid && in_tready;
    assign out_fire  = M_AXIS_tvalid && M_AXIS_tready;

    // The first beat of a packet uses poly_q directly; later beats reuse the latched width.
    assign w_beat = busy ? w : width_of(poly_q);

    always_comb begin
        acc_nxt   = acc;
        cnt_nxt   = cnt;
        flush_nxt = flush;
        w_nxt     = w;
        busy_nxt  = busy;
        if (in_fire) begin
            acc_nxt  = acc | place(in_tdata, w_beat, cnt);
            cnt_nxt  = cnt + {2'b00, w_beat};
            w_nxt    = w_beat;
            busy_nxt = 1'b1;
            if (in_tlast)
                flush_nxt = 1'b1;
        end else if (out_fire) begin
            if (M_AXIS_tlast) begin
                acc_nxt   = '0;
                cnt_nxt   = '0;
                flush_nxt = 1'b0;
                busy_nxt  = 1'b0;
            end else begin
                acc_nxt = acc >> 32;
                cnt_nxt = (cnt >= 6'd32) ? cnt - 6'd32 : 6'd0;
            end
        end
    end

    // Output word is registered from next state, so it appears one cycle after
    // the completing beat and holds still while the sink stalls.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc           <= '0;
            cnt           <= '0;
            flush         <= 1'b0;
            w             <= 4'd13;
            busy          <= 1'b0;
            M_AXIS_tdata  <= '0;
            M_AXIS_tvalid <= 1'b0;
            M_AXIS_tlast  <= 1'b0;
        end else begin
            acc           <= acc_nxt;
            cnt           <= cnt_nxt;
            flush         <= flush_nxt;
            w             <= w_nxt;
            busy          <= busy_nxt;
            M_AXIS_tdata  <= acc_nxt[31:0];
            M_AXIS_tvalid <= (cnt_nxt >= 6'd32) || (flush_nxt && (cnt_nxt != 6'd0));
            M_AXIS_tlast  <= flush_nxt && (cnt_nxt <= 6'd32);
        end
    end

endmodule

// File: tb/tb_coeff_stream_packer.sv
// Scoreboard bench for coeff_stream_packer: expected words are queued as
// packets are driven and compared as the DUT emits them.
module tb_coeff_stream_packer;

    logic        clk = 1'b0;
    logic        reset;
    logic [12:0] in_tdata;
    logic        in_tvalid;
    logic        in_tready;
    logic        in_tlast;
    logic [1:0]  poly_q;
    logic [31:0] M_AXIS_tdata;
    logic        M_AXIS_tvalid;
    logic        M_AXIS_tready;
    logic        M_AXIS_tlast;
    logic        busy;

    coeff_stream_packer dut (
        .clk           (clk),
        .reset         (reset),
        .in_tdata      (in_tdata),
        .in_tvalid     (in_tvalid),
        .in_tready     (in_tready),
        .in_tlast      (in_tlast),
        .poly_q        (poly_q),
        .M_AXIS_tdata  (M_AXIS_tdata),
        .M_AXIS_tvalid (M_AXIS_tvalid),
        .M_AXIS_tready (M_AXIS_tready),
        .M_AXIS_tlast  (M_AXIS_tlast),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [32:0] exp_q[$];
    logic [12:0] pkt[$];
    int          bp_mode = 0;
    bit          held    = 0;
    logic [32:0] held_word;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int w_of(input logic [1:0] q);
        return (q == 2'd0) ? 11 : (q == 2'd1) ? 12 : 13;
    endfunction

    // Reference packer: serialise coefficient bits LSB-first, then cut 32-bit words.
    task automatic model_packet(input int w, input bit partial);
        bit          bits[$];
        logic [31:0] word;
        foreach (pkt[i])
            for (int b = 0; b < w; b++) bits.push_back(pkt[i][b]);
        while (bits.size() > 0 && (!partial || bits.size() >= 32)) begin
            word = '0;
            for (int i = 0; i < 32; i++)
                if (bits.size() > 0) word[i] = bits.pop_front();
            exp_q.push_back({!partial && bits.size() == 0, word});
        end
    endtask

    // Sink backpressure: 0 always ready, 1 random, 2 held off.
    initial begin
        M_AXIS_tready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            case (bp_mode)
                0:       M_AXIS_tready = 1'b1;
                1:       M_AXIS_tready = ($urandom_range(0, 3) != 0);
                default: M_AXIS_tready = 1'b0;
            endcase
        end
    end

    always @(negedge clk) begin
        if (!reset && M_AXIS_tvalid) begin
            check("in_tready_while_out", in_tready, 1'b0);
            if (held)
                check("stall_stable", {M_AXIS_tlast, M_AXIS_tdata}, held_word);
            if (M_AXIS_tready) begin
                if (exp_q.size() == 0)
                    check("extra_word", exp_q.size(), 1);
                else
                    check("word", {M_AXIS_tlast, M_AXIS_tdata}, exp_q.pop_front());
                held = 0;
            end else begin
                held      = 1;
                held_word = {M_AXIS_tlast, M_AXIS_tdata};
            end
        end else begin
            held = 0;
        end
    end

    task automatic send_beat(input logic [12:0] d, input bit l);
        int g = 0;
        in_tdata  = d;
        in_tlast  = l;
        in_tvalid = 1'b1;
        while (!in_tready && g < 2000) begin
            @(negedge clk);
            g++;
        end
        if (!in_tready) check("in_timeout", g, 0);
        @(negedge clk);
    endtask

    task automatic send_packet(input logic [1:0] q, input bit has_last, input bit toggle_q);
        poly_q = q;
        for (int i = 0; i < pkt.size(); i++) begin
            send_beat(pkt[i], has_last && (i == pkt.size() - 1));
            if (i == 0) begin
                check("busy_set", busy, 1'b1);
                if (toggle_q) poly_q = ~q;
            end
        end
        in_tvalid = 1'b0;
        in_tlast  = 1'b0;
    endtask

    task automatic wait_drain();
        int g = 0;
        while ((exp_q.size() != 0 || busy) && g < 5000) begin
            @(negedge clk);
            g++;
        end
        check("drain_queue", exp_q.size(), 0);
        check("drain_busy", busy, 1'b0);
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_in_tready"}, in_tready, 1'b0);
        check({tag, "_tvalid"}, M_AXIS_tvalid, 1'b0);
        check({tag, "_tlast"}, M_AXIS_tlast, 1'b0);
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_tdata"}, M_AXIS_tdata, 32'h0);
    endtask

    task automatic run_basic11();
        pkt = '{13'h7FF, 13'h001, 13'h400};
        exp_q.push_back({1'b0, 32'h00000FFF});
        exp_q.push_back({1'b1, 32'h00000001});
        send_packet(2'd0, 1'b1, 1'b0);
        wait_drain();
    endtask

    initial begin
        int g;
        reset     = 1'b1;
        in_tdata  = '0;
        in_tvalid = 1'b0;
        in_tlast  = 1'b0;
        poly_q    = 2'd0;
        repeat (3) @(negedge clk);
        check_idle("reset");
        reset = 1'b0;
        @(negedge clk);

        run_basic11();

        // 12-bit packet with the sink stalled while the first word is pending.
        bp_mode = 2;
        pkt.delete();
        repeat (8) pkt.push_back(13'hABC);
        exp_q.push_back({1'b0, 32'hBCABCABC});
        exp_q.push_back({1'b0, 32'hCABCABCA});
        exp_q.push_back({1'b1, 32'hABCABCAB});
        fork
            send_packet(2'd1, 1'b1, 1'b0);
            begin
                g = 0;
                while (!M_AXIS_tvalid && g < 200) begin
                    @(negedge clk);
                    g++;
                end
                for (int i = 0; i < 10; i++) begin
                    check("stall_tvalid", M_AXIS_tvalid, 1'b1);
                    @(negedge clk);
                end
                bp_mode = 0;
            end
        join
        wait_drain();

        // Long 13-bit packet under random backpressure.
        bp_mode = 1;
        pkt.delete();
        repeat (509) pkt.push_back(13'h1FFF);
        repeat (206) exp_q.push_back({1'b0, 32'hFFFFFFFF});
        exp_q.push_back({1'b1, 32'h01FFFFFF});
        send_packet(2'd2, 1'b1, 1'b0);
        wait_drain();

        // Over-wide input masked to 11 bits; poly_q change mid-packet ignored.
        bp_mode = 0;
        pkt = '{13'h1FFF, 13'h1FFF, 13'h1FFF};
        exp_q.push_back({1'b0, 32'hFFFFFFFF});
        exp_q.push_back({1'b1, 32'h00000001});
        send_packet(2'd0, 1'b1, 1'b1);
        wait_drain();

        bp_mode = 1;
        for (int p = 0; p < 6; p++) begin
            logic [1:0] q;
            int         n;
            q = 2'($urandom_range(0, 3));
            n = $urandom_range(1, 24);
            pkt.delete();
            for (int i = 0; i < n; i++) pkt.push_back(13'($urandom));
            model_packet(w_of(q), 1'b0);
            send_packet(q, 1'b1, 1'b0);
            wait_drain();
        end

        // Reset in the middle of a packet: only the completed word escapes.
        bp_mode = 0;
        pkt.delete();
        repeat (5) pkt.push_back(13'h7FF);
        model_packet(11, 1'b1);
        send_packet(2'd0, 1'b0, 1'b0);
        g = 0;
        while (exp_q.size() != 0 && g < 200) begin
            @(negedge clk);
            g++;
        end
        check("partial_queue", exp_q.size(), 0);
        repeat (2) @(negedge clk);
        check("partial_busy", busy, 1'b1);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check_idle("midreset");
        reset = 1'b0;
        @(negedge clk);
        check("post_reset_busy", busy, 1'b0);
        check("post_reset_tvalid", M_AXIS_tvalid, 1'b0);

        run_basic11();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
